// File: rtl/uc_seq.sv
// Control unit for the single-cycle 8-bit microcontroller: combinational decode plus RUN/WAIT/HALT sequencing.
// Latency: controls are valid in the same cycle the opcode is presented; flags and icount update on the next edge.
// Backpressure: pc_hold stalls the PC and suppresses all register and flag writes while WAIT or HALT is in progress.
module uc_seq #(
    parameter int WAIT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op,
    output logic             pc_hold,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_HALT
    } state_t;

    // The first WAIT cycle is spent in RUN, so the counter covers the remaining cycles minus the exit cycle.
    localparam logic [7:0] WAIT_INIT = (WAIT_CYCLES > 1) ? 8'(WAIT_CYCLES - 2) : 8'd0;

    state_t           state, state_nxt;
    logic [7:0]       wait_cnt, wait_cnt_nxt;
    logic             illegal_dec;
    logic             halted_q, illegal_q;
    logic [CNT_W-1:0] icount_q;

    logic             s_inc_c, s_inm_c, we3_c, wez_c, hold_c;
    logic [2:0]       op_c;

    always_comb begin
        s_inc_c      = 1'b1;
        s_inm_c      = 1'b0;
        we3_c        = 1'b0;
        wez_c        = 1'b0;
        op_c         = 3'b000;
        hold_c       = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        illegal_dec  = 1'b0;

        case (state)
            S_RUN: begin
                casez (opcode)
                    6'b1?????: begin
                        op_c  = opcode[4:2];
                        we3_c = 1'b1;
                        wez_c = 1'b1;
                    end
                    6'b0000??: begin
                        s_inm_c = 1'b1;
                        we3_c   = 1'b1;
                    end
                    6'b000100: s_inc_c = 1'b0;
                    6'b000101: s_inc_c = ~z;
                    6'b000110: s_inc_c = z;
                    6'b000111: begin
                        hold_c    = 1'b1;
                        state_nxt = S_HALT;
                    end
                    6'b001000: begin
                        if (WAIT_CYCLES > 1) begin
                            hold_c       = 1'b1;
                            wait_cnt_nxt = WAIT_INIT;
                            state_nxt    = S_WAIT;
                        end
                    end
                    6'b001001: ;
                    default:   illegal_dec = 1'b1;
                endcase
            end
            S_WAIT: begin
                if (wait_cnt != 8'd0) begin
                    hold_c       = 1'b1;
                    wait_cnt_nxt = wait_cnt - 8'd1;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_HALT: hold_c = 1'b1;
            default: state_nxt = S_RUN;
        endcase

        // Held cycles must never change architectural state.
        if (hold_c) begin
            we3_c = 1'b0;
            wez_c = 1'b0;
        end
    end

    // Reset overrides the decoded controls immediately, without waiting for an edge.
    always_comb begin
        if (!reset) begin
            s_inc   = 1'b1;
            s_inm   = 1'b0;
            we3     = 1'b0;
            wez     = 1'b0;
            op      = 3'b000;
            pc_hold = 1'b0;
        end else begin
            s_inc   = s_inc_c;
            s_inm   = s_inm_c;
            we3     = we3_c;
            wez     = wez_c;
            op      = op_c;
            pc_hold = hold_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_RUN;
            wait_cnt  <= 8'd0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            icount_q  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (illegal_dec)
                illegal_q <= 1'b1;
            if (state_nxt == S_HALT)
                halted_q <= 1'b1;
            if (!hold_c && (icount_q != {CNT_W{1'b1}}))
                icount_q <= icount_q + CNT_W'(1);
        end
    end

    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign icount  = icount_q;

endmodule

// File: doc/uc_seq.md
Name: uc_seq

Overview:
- Sequential control unit for the single-cycle 8-bit microcontroller datapath.
- Consumes the 6-bit opcode and the registered zero flag from the datapath.
- Drives the datapath's PC mux select, immediate select, register-file write, flag write and ALU operation.
- Adds three sequential features: a multi-cycle WAIT instruction, a sticky HALT, and a retired-instruction counter.
- Requires a PC write-enable in the datapath, driven by pc_hold.

Parameters:
WAIT_CYCLES, 4, total cycles a WAIT instruction occupies (legal range 1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
opcode  input  6  instruction bits [15:10] from program memory
z  input  1  registered zero flag from datapath
s_inc  output  1  PC mux select: 1 = PC+1, 0 = jump address
s_inm  output  1  register write-data select: 1 = immediate, 0 = ALU result
we3  output  1  register file write enable
wez  output  1  zero-flag register write enable
op  output  3  ALU operation
pc_hold  output  1  1 = PC must not update this cycle
halted  output  1  sticky, high after HALT executes
illegal  output  1  sticky, high after any undefined opcode
icount  output  CNT_W  retired-instruction count, saturating

Behaviour:
- Reset (reset=0, async) forces the following:
  - state=RUN, wait counter=0.
  - icount=0, halted=0, illegal=0.
  - Outputs: s_inc=1, s_inm=0, we3=0, wez=0, op=000, pc_hold=0.
- Decode is combinational from opcode, z and state. There is no added latency: controls are valid in the same cycle the opcode is presented.
- Opcode map:
  - 1xxxxx, ALU op: op=opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1.
  - 0000xx, load immediate: s_inm=1, we3=1, wez=0, s_inc=1.
  - 000100, JMP: s_inc=0.
  - 000101, JZ: s_inc=~z.
  - 000110, JNZ: s_inc=z.
  - 000111, HALT.
  - 001000, WAIT.
  - 001001, NOP: s_inc=1, no writes.
  - Any other opcode: executes as NOP and sets illegal (sticky until reset).
- Unless stated otherwise, op=000, s_inm=0, we3=0, wez=0.
- States: RUN, WAIT, HALT.
- RUN:
  - Normal decode.
  - WAIT opcode with WAIT_CYCLES=1: behaves as NOP.
  - WAIT opcode with WAIT_CYCLES>1: pc_hold=1, counter<=WAIT_CYCLES-2, next state WAIT.
  - HALT opcode: pc_hold=1, next state HALT.
- WAIT:
  - pc_hold=1 and all writes 0 while counter!=0; counter decrements each cycle.
  - When counter==0: pc_hold=0, s_inc=1, next state RUN.
  - Net effect: the WAIT instruction occupies exactly WAIT_CYCLES cycles.
- HALT:
  - pc_hold=1, we3=0, wez=0, s_inc=1, halted=1, regardless of opcode.
  - The only exit is reset.
- pc_hold=1 always forces we3=0 and wez=0, so no architectural state changes while held.
- icount increments on every cycle where pc_hold=0 (instruction retired). This includes taken and untaken jumps and the final WAIT cycle.
- icount saturates at all-ones and never wraps.
- Reset asserted mid-WAIT or in HALT: immediate return to RUN. Counter and all sticky flags clear asynchronously.
- z is sampled only in the cycle a conditional jump is decoded. The flag written by the preceding ALU instruction is the one used.

Test Plan:
- Reset, then ALU opcode 101100 (op=011) with z=0 -> op=011, we3=1, wez=1, s_inm=0, s_inc=1, pc_hold=0; icount 0->1 next edge.
- Opcode 000101 (JZ) with z=1 -> s_inc=0. Same opcode with z=0 -> s_inc=1. JNZ 000110 gives the inverse for both z values.
- WAIT_CYCLES=4, WAIT opcode held 4 cycles:
  - pc_hold = 1,1,1,0.
  - we3=wez=0 throughout.
  - icount increments only on cycle 4.
  - WAIT_CYCLES=1 run: pc_hold stays 0.
- HALT 000111, then ALU opcodes applied for 10 cycles:
  - pc_hold=1, halted=1, we3=0 every cycle.
  - icount frozen.
  - reset=0 pulse clears halted, returns to RUN.
- Opcode 111111 vs 001111: 111111 decodes as ALU op 111. 001111 causes illegal=1 with no writes and s_inc=1; illegal stays 1 for following legal opcodes until reset.
- Assert reset=0 asynchronously (between edges) during cycle 2 of a WAIT -> outputs drop to reset values without a clock edge. After release the next WAIT again lasts the full WAIT_CYCLES.
- CNT_W=4 with 20 retired NOPs -> icount reaches 15 and holds at 15.
